serial_adder: RTL
=================

# serial_adder

Bit-serial WIDTH-bit adder built around a single full-adder cell and a carry flip-flop. It processes operands LSB-first, one bit per clock. It is the additive counterpart of the team's full-subtractor cells and serves area-constrained datapaths where a ripple adder of WIDTH cells is too large. A start/busy/done handshake frames each operation, and results are held stable until the next operation completes.

## Interface
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle (busy = 0).
- a  input  WIDTH  augend; captured on the accepted start edge.
- b  input  WIDTH  addend; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum/cout/ovf are updated.
- sum  output  WIDTH  registered result a + b + cin, modulo 2^WIDTH.
- cout  output  1  unsigned carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Reset: busy = 0, done = 0, sum = 0, cout = 0, ovf = 0; all internal shift registers, the carry flip-flop and the bit counter are cleared; state = IDLE.
- The FSM has two states: IDLE and RUN.
- IDLE with start = 1 on a clock edge:
  - load the shift registers with a and b, and the carry flip-flop with cin;
  - clear the bit counter;
  - go to RUN with busy = 1.
- IDLE with start = 0: hold. done drops to 0 if it was set.
- RUN, on each edge:
  - s = a_sh[0] ^ b_sh[0] ^ c;
  - c <= (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
  - shift a_sh and b_sh right by one;
  - shift s into the MSB of the internal result register acc;
  - increment the counter.
- On the processing edge of bit WIDTH-2, latch the carry into the MSB as cmsb, for use by ovf.
- On the processing edge of bit WIDTH-1 (the counter reaches WIDTH):
  - sum <= the final acc value, including that bit;
  - cout <= the final carry;
  - ovf <= cmsb ^ final carry;
  - done <= 1, busy <= 0, go to IDLE.
- sum, cout and ovf change only on the completion edge. They are never partial during RUN.
- start asserted during RUN is ignored. It is not queued.
- a, b and cin are don't-care except on the accepted start edge.
- rst has priority over all other inputs in every state. Asserting it mid-operation aborts the operation: no done pulse, outputs cleared as in reset.
- Size the counter to $clog2(WIDTH+1) bits. It never wraps during a legal operation.

## Timing
- Let edge E0 be the edge that accepts start.
  - busy is high from E0 through E0+WIDTH, and falls after edge E0+WIDTH.
  - done is high for exactly the one cycle following edge E0+WIDTH.
  - Latency is WIDTH+1 cycles from the start cycle to the done cycle.
- Back-to-back operation: start asserted during the done cycle is accepted, because the FSM is already in IDLE. Throughput is therefore one operation per WIDTH+1 cycles.
- done and busy are never high in the same cycle.
- done is a pulse: it is cleared on the next edge regardless of start.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> after 9 cycles: done pulse, sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Also a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
- a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1. Also a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Start 0x12+0x34, then pulse start with a=0xFF, b=0xFF three cycles later -> second request ignored: single done with sum=0x46; sum stays at its previous value until completion.
- Assert rst for one cycle at RUN bit 4 -> next cycle busy=0, done=0, sum=0; no done pulse follows; a new start then completes normally.
- Re-assert start in the done cycle with 0x01+0x01 -> accepted; second done exactly 9 cycles later with sum=0x02; 200 random operands checked against a+b+cin, including ovf.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operation bundle for the bit-serial adder: request/operands in, status/result out.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, operands consumed LSB-first.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             c_reg, cmsb_reg, cout_reg, ovf_reg, done_reg;
    logic             s_bit, c_next, last_bit, msb_in_bit;

    assign s_bit      = a_sh_reg[0] ^ b_sh_reg[0] ^ c_reg;
    assign c_next     = (a_sh_reg[0] & b_sh_reg[0]) | (c_reg & (a_sh_reg[0] ^ b_sh_reg[0]));
    assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
    assign msb_in_bit = (cnt_reg == CW'(WIDTH - 2));

    // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_acc_shift
            assign acc_next[gi] = acc_reg[gi + 1];
        end
    endgenerate
    assign acc_next[WIDTH-1] = s_bit;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg <= '0;
            b_sh_reg <= '0;
            acc_reg  <= '0;
            sum_reg  <= '0;
            cnt_reg  <= '0;
            c_reg    <= 1'b0;
            cmsb_reg <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_reg <= bus.a;
                        b_sh_reg <= bus.b;
                        c_reg    <= bus.cin;
                        cnt_reg  <= '0;
                    end
                end
                RUN: begin
                    c_reg    <= c_next;
                    a_sh_reg <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    acc_reg  <= acc_next;
                    cnt_reg  <= cnt_reg + CW'(1);
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (msb_in_bit) cmsb_reg <= c_next;
                    if (last_bit) begin
                        sum_reg  <= acc_next;
                        cout_reg <= c_next;
                        ovf_reg  <= cmsb_reg ^ c_next;
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule
